fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. Holds the fetch PC, issues word reads to an instruction memory with variable latency (at most one outstanding request), buffers one returned word, and drives the F/D pipeline register consumed by decode. It sits directly upstream of decode and obeys the hazard unit's stall_f/stall_d/flush_d, branch (pc_src) and jump redirect signals.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit_fetch_buffer.sv | 52 +++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    localparam addr_t RESET_PC  = 32'h0000_0000;
    localparam word_t NOP_INSTR = 32'h0000_0000;   // sll $0,$0,0

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_KILL
    } fetch_state_t;

    function automatic addr_t pc_inc(input addr_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: one request channel, one response channel.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  imem_req;
    addr_t imem_addr;
    logic  imem_ready;
    logic  imem_rvalid;
    word_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_unit_fetch_buffer.sv
// Single-entry skid buffer holding a returned word while decode is stalled.
module fetch_buffer
    import fetch_unit_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load_i,
    input  logic  consume_i,
    input  logic  clear_i,
    input  word_t instr_i,
    input  addr_t pc_i,
    output logic  valid_o,
    output word_t instr_o,
    output addr_t pc_o
);

    logic  valid_q, valid_d;
    word_t instr_q, instr_d;
    addr_t pc_q,    pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding imem read, one-word buffer, F/D register.
//   state   | meaning
//   ST_IDLE | nothing outstanding
//   ST_WAIT | one request outstanding, response wanted
//   ST_KILL | one request outstanding, response discarded (redirected)
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         stall_f_i,
    input  logic         stall_d_i,
    input  logic         flush_d_i,
    input  logic         pc_src_d_i,
    input  addr_t        pc_branch_d_i,
    input  logic [2:0]   jump_d_i,
    input  addr_t        pc_jump_d_i,
    fetch_unit_if.master imem,
    output word_t        instr_d_o,
    output addr_t        pc_plus_4_d_o,
    output logic         valid_d_o
);

    fetch_state_t state_q, state_d;
    addr_t        pc_f_q, pc_f_d;
    addr_t        req_pc_q, req_pc_d;
    word_t        instr_d_q, instr_d_d;
    addr_t        pc4_d_q, pc4_d_d;
    logic         valid_d_q, valid_d_d;

    logic  redirect, advance, resp, take_fd;
    logic  fb_valid, fb_load, fb_consume, fb_free, bypass;
    logic  req, accept;
    addr_t target;
    word_t fb_instr;
    addr_t fb_pc;

    fetch_buffer u_fetch_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (fb_load),
        .consume_i (fb_consume),
        .clear_i   (redirect),
        .instr_i   (imem.imem_rdata),
        .pc_i      (req_pc_q),
        .valid_o   (fb_valid),
        .instr_o   (fb_instr),
        .pc_o      (fb_pc)
    );

    always_comb begin
        redirect   = ~stall_d_i & (pc_src_d_i | (jump_d_i != 3'd0));
        target     = pc_src_d_i ? pc_branch_d_i : pc_jump_d_i;
        advance    = ~stall_d_i;
        resp       = imem.imem_rvalid & (state_q == ST_WAIT);
        take_fd    = advance & ~flush_d_i & ~redirect;
        fb_consume = take_fd & fb_valid;
        bypass     = take_fd & ~fb_valid & resp;
        // a response on a redirected path is dropped, never buffered
        fb_load    = resp & ~bypass & ~redirect;
        fb_free    = (~fb_valid | fb_consume) & ~fb_load;
        req        = ~rst_i & ~stall_f_i & ~redirect &
                     ((state_q == ST_IDLE) | resp) & fb_free;
        accept     = req & imem.imem_ready;
    end

    always_comb begin
        state_d   = state_q;
        pc_f_d    = pc_f_q;
        req_pc_d  = req_pc_q;
        instr_d_d = instr_d_q;
        pc4_d_d   = pc4_d_q;
        valid_d_d = valid_d_q;

        case (state_q)
            ST_IDLE: if (accept) state_d = ST_WAIT;
            ST_WAIT: begin
                if (imem.imem_rvalid)
                    state_d = accept ? ST_WAIT : ST_IDLE;
                else if (redirect)
                    state_d = ST_KILL;
            end
            ST_KILL: if (imem.imem_rvalid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (redirect)
            pc_f_d = target;
        else if (accept)
            pc_f_d = pc_inc(pc_f_q);

        if (accept)
            req_pc_d = pc_f_q;

        if (advance) begin
            if (flush_d_i || redirect) begin
                instr_d_d = NOP_INSTR;
                valid_d_d = 1'b0;
            end else if (fb_valid) begin
                instr_d_d = fb_instr;
                pc4_d_d   = pc_inc(fb_pc);
                valid_d_d = 1'b1;
            end else if (resp) begin
                instr_d_d = imem.imem_rdata;
                pc4_d_d   = pc_inc(req_pc_q);
                valid_d_d = 1'b1;
            end else begin
                instr_d_d = NOP_INSTR;
                valid_d_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pc_f_q    <= RESET_PC;
            req_pc_q  <= RESET_PC;
            instr_d_q <= NOP_INSTR;
            pc4_d_q   <= '0;
            valid_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_f_q    <= pc_f_d;
            req_pc_q  <= req_pc_d;
            instr_d_q <= instr_d_d;
            pc4_d_q   <= pc4_d_d;
            valid_d_q <= valid_d_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_f_q;
    assign instr_d_o      = instr_d_q;
    assign pc_plus_4_d_o  = pc4_d_q;
    assign valid_d_o      = valid_d_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns word == address after lat cycles.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, flush_d, pc_src;
    logic [31:0] pc_branch, pc_jump;
    logic [2:0]  jump;
    logic [31:0] instr_d, pc4_d;
    logic        valid_d;

    int          checks   = 0;
    int          failures = 0;
    int          mem_lat  = 1;
    int          mem_cnt  = 0;
    logic [31:0] mem_a    = 32'h0;

    fetch_unit_if mif ();

    fetch_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_f_i     (stall_f),
        .stall_d_i     (stall_d),
        .flush_d_i     (flush_d),
        .pc_src_d_i    (pc_src),
        .pc_branch_d_i (pc_branch),
        .jump_d_i      (jump),
        .pc_jump_d_i   (pc_jump),
        .imem          (mif),
        .instr_d_o     (instr_d),
        .pc_plus_4_d_o (pc4_d),
        .valid_d_o     (valid_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mif.imem_req && mif.imem_ready) begin
            mem_cnt <= mem_lat;
            mem_a   <= mif.imem_addr;
        end else if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    assign mif.imem_rvalid = (mem_cnt == 1);
    assign mif.imem_rdata  = mem_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fd(input string tag, input logic v, input logic [31:0] p4,
                          input logic [31:0] ins);
        chk({tag, ".valid"}, {31'd0, valid_d}, {31'd0, v});
        chk({tag, ".pc4"}, pc4_d, p4);
        chk({tag, ".instr"}, instr_d, ins);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'd0, mif.imem_req}, {31'd0, r});
        if (r) chk({tag, ".addr"}, mif.imem_addr, a);
    endtask

    initial begin
        rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src = 1'b0; pc_branch = 32'h0; jump = 3'd0; pc_jump = 32'h0;
        mif.imem_ready = 1'b1;
        #2;
        chk_fd("reset", 1'b0, 32'h0, 32'h0);
        chk_req("reset", 1'b0, 32'h0);

        // cycle 0: reset released, zero-wait memory
        @(negedge clk); rst = 1'b0; #1;
        chk_req("c0", 1'b1, 32'h0);
        chk_fd("c0", 1'b0, 32'h0, 32'h0);
        @(negedge clk); #1;
        chk_req("c1", 1'b1, 32'h4);
        chk_fd("c1", 1'b0, 32'h0, 32'h0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk); #1;
            chk_fd("zw", 1'b1, 32'(4 * (c - 1)), 32'(4 * (c - 2)));
            chk_req("zw", 1'b1, 32'(4 * c));
        end

        // cycles 5-7: ready low; then 2-cycle latency
        @(negedge clk); mif.imem_ready = 1'b0; mem_lat = 2; #1;
        chk_fd("c5", 1'b1, 32'd16, 32'd12);
        chk_req("c5", 1'b1, 32'd20);
        @(negedge clk); #1;
        chk_fd("c6", 1'b1, 32'd20, 32'd16);
        chk_req("c6", 1'b1, 32'd20);
        @(negedge clk); #1;
        chk_fd("c7", 1'b0, 32'd20, 32'h0);
        @(negedge clk); mif.imem_ready = 1'b1; #1;
        chk_fd("c8", 1'b0, 32'd20, 32'h0);
        chk_req("c8", 1'b1, 32'd20);
        @(negedge clk); #1;
        chk_fd("c9", 1'b0, 32'd20, 32'h0);
        chk_req("c9", 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_fd("c10", 1'b0, 32'd20, 32'h0);
        chk_req("c10", 1'b1, 32'd24);
        @(negedge clk); #1;
        chk_fd("c11", 1'b1, 32'd24, 32'd20);
        chk_req("c11", 1'b0, 32'h0);
        @(negedge clk); mem_lat = 1; #1;
        chk_fd("c12", 1'b0, 32'd24, 32'h0);
        chk_req("c12", 1'b1, 32'd28);
        @(negedge clk); #1;
        chk_fd("c13", 1'b1, 32'd28, 32'd24);
        chk_req("c13", 1'b1, 32'd32);

        // cycles 14-16: decode stall while word 32 returns
        @(negedge clk); stall_d = 1'b1; #1;
        chk_fd("st14", 1'b1, 32'd32, 32'd28);
        chk_req("st14", 1'b0, 32'h0);
        for (int c = 15; c <= 16; c++) begin
            @(negedge clk); #1;
            chk_fd("st_hold", 1'b1, 32'd32, 32'd28);
            chk_req("st_hold", 1'b0, 32'h0);
        end
        @(negedge clk); stall_d = 1'b0; #1;
        chk_fd("st17", 1'b1, 32'd32, 32'd28);
        chk_req("st17", 1'b1, 32'd36);
        @(negedge clk); #1;
        chk_fd("st18", 1'b1, 32'd36, 32'd32);
        chk_req("st18", 1'b1, 32'd40);

        // cycle 20: branch to 0x100 while request to 44 is outstanding
        @(negedge clk); mem_lat = 2; #1;
        chk_fd("c19", 1'b1, 32'd40, 32'd36);
        chk_req("c19", 1'b1, 32'd44);
        @(negedge clk); pc_src = 1'b1; pc_branch = 32'h100; #1;
        chk_fd("br20", 1'b1, 32'd44, 32'd40);
        chk_req("br20", 1'b0, 32'h0);
        @(negedge clk); pc_src = 1'b0; #1;
        chk_fd("br21", 1'b0, 32'd44, 32'h0);
        chk_req("br21", 1'b0, 32'h0);
        chk("br21.pc_f", mif.imem_addr, 32'h100);
        @(negedge clk); mem_lat = 1; #1;
        chk_fd("br22", 1'b0, 32'd44, 32'h0);
        chk_req("br22", 1'b1, 32'h100);
        @(negedge clk); #1;
        chk_fd("br23", 1'b0, 32'd44, 32'h0);
        chk_req("br23", 1'b1, 32'h104);
        @(negedge clk); #1;
        chk_fd("br24", 1'b1, 32'h104, 32'h100);

        // cycles 25-26: branch+jump under decode stall are ignored
        @(negedge clk);
        stall_d = 1'b1; pc_src = 1'b1; pc_branch = 32'h200; jump = 3'd1; pc_jump = 32'h300;
        #1;
        chk_fd("bj25", 1'b1, 32'h108, 32'h104);
        chk_req("bj25", 1'b0, 32'h0);
        @(negedge clk); #1;
        chk_fd("bj26", 1'b1, 32'h108, 32'h104);
        chk("bj26.pc_f", mif.imem_addr, 32'h10c);
        @(negedge clk); stall_d = 1'b0; #1;
        chk_req("bj27", 1'b0, 32'h0);
        @(negedge clk); pc_src = 1'b0; jump = 3'd0; #1;
        chk_fd("bj28", 1'b0, 32'h108, 32'h0);
        chk_req("bj28", 1'b1, 32'h200);
        @(negedge clk); #1;
        chk_fd("bj29", 1'b0, 32'h108, 32'h0);
        chk_req("bj29", 1'b1, 32'h204);

        // cycle 31: reset during WAIT, stale response arrives in cycle 32
        @(negedge clk); mem_lat = 2; #1;
        chk_fd("c30", 1'b1, 32'h204, 32'h200);
        chk_req("c30", 1'b1, 32'h208);
        @(negedge clk); #1;
        chk_fd("c31", 1'b1, 32'h208, 32'h204);
        rst = 1'b1; #1;
        chk_fd("rst31", 1'b0, 32'h0, 32'h0);
        chk_req("rst31", 1'b0, 32'h0);
        @(negedge clk); rst = 1'b0; mem_lat = 1; #1;
        chk_fd("rst32", 1'b0, 32'h0, 32'h0);
        chk_req("rst32", 1'b1, 32'h0);
        @(negedge clk); #1;
        chk_fd("rst33", 1'b0, 32'h0, 32'h0);
        chk_req("rst33", 1'b1, 32'h4);
        @(negedge clk); #1;
        chk_fd("rst34", 1'b1, 32'h4, 32'h0);
        @(negedge clk); #1;
        chk_fd("rst35", 1'b1, 32'h8, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
